// File: rtl/ppm_m_demod_pkg.sv
// Shared types and protocol constants for the M-ary PPM demodulator.
package ppm_m_demod_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_SFD      = 3'd3,
        ST_HEADER   = 3'd4,
        ST_DATA     = 3'd5
    } state_t;

    // Framing symbols. The preamble uses the top chip so that stale window
    // contents, which only move toward lower chips while scanning, can never
    // mimic it.
    localparam int PREAMBLE_SYMBOL = 15;
    localparam int SFD0_SYMBOL     = 9;
    localparam int SFD1_SYMBOL     = 6;

endpackage

// File: rtl/ppm_m_demod_correlator.sv
// Combinational chip correlator: per-chip popcount, argmax (lowest index on
// ties) and threshold test against the peak magnitude.
module ppm_m_demod_correlator #(
    parameter int SYM_BITS     = 4,
    parameter int CHIP_SAMPLES = 2
) (
    input  logic [(2**SYM_BITS)*CHIP_SAMPLES-1:0] window,
    input  logic [$clog2(CHIP_SAMPLES+1)-1:0]     threshold,
    output logic [SYM_BITS-1:0]                   sym,
    output logic                                  unmet
);
    localparam int M     = 2**SYM_BITS;
    localparam int MAG_W = $clog2(CHIP_SAMPLES+1);

    logic [MAG_W-1:0] mag [M];
    logic [MAG_W-1:0] peak;

    // Magnitude of each chip is the number of 1 samples it holds.
    always_comb begin
        for (int k = 0; k < M; k++) begin
            mag[k] = '0;
            for (int j = 0; j < CHIP_SAMPLES; j++) begin
                mag[k] = mag[k] + MAG_W'(window[k*CHIP_SAMPLES+j]);
            end
        end
    end

    // Strict greater-than keeps the lowest index when magnitudes tie.
    always_comb begin
        peak = mag[0];
        sym  = '0;
        for (int k = 1; k < M; k++) begin
            if (mag[k] > peak) begin
                peak = mag[k];
                sym  = SYM_BITS'(k);
            end
        end
    end

    assign unmet = (peak < threshold);

endmodule

// File: rtl/ppm_m_demod.sv
// M-ary PPM demodulator: sample window, framing FSM, length header and
// data symbol output with carrier-loss and overrun reporting.
//
//  state     | meaning
//  IDLE      | window frozen, waiting for rx_start
//  SCAN      | sliding search for an aligned preamble symbol
//  PREAMBLE  | counting preamble symbols, then expecting SFD0
//  SFD       | expecting SFD1
//  HEADER    | collecting the length field, MSB symbol first
//  DATA      | emitting data_len symbols
module ppm_m_demod
    import ppm_m_demod_pkg::*;
#(
    parameter int SYM_BITS     = 4,
    parameter int CHIP_SAMPLES = 2,
    parameter int PREAMBLE_MIN = 2,
    parameter int LEN_SYMS     = 4,
    parameter int MISS_MAX     = 3
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                din,
    input  logic                                rx_start,
    input  logic                                rx_abort,
    input  logic [$clog2(CHIP_SAMPLES+1)-1:0]   corr_threshold,
    input  logic                                dout_ready,
    output logic                                dout_valid,
    output logic [SYM_BITS-1:0]                 dout,
    output logic                                packet_detected,
    output logic                                packet_done,
    output logic                                carrier_lost,
    output logic                                overrun,
    output logic [LEN_SYMS*SYM_BITS-1:0]        data_len,
    output logic [2:0]                          state_sc
);
    localparam int M      = 2**SYM_BITS;
    localparam int WIN    = M*CHIP_SAMPLES;
    localparam int LEN_W  = LEN_SYMS*SYM_BITS;
    localparam int CNT_W  = $clog2(WIN);
    localparam int RUN_W  = $clog2(PREAMBLE_MIN+1);
    localparam int HDR_W  = $clog2(LEN_SYMS+1);
    localparam int MISS_W = $clog2(MISS_MAX+1);

    state_t              state, state_nx;
    logic [WIN-1:0]      window;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [RUN_W-1:0]    run, run_nx;
    logic [HDR_W-1:0]    hdr_cnt, hdr_nx;
    logic [LEN_W-1:0]    dcnt, dcnt_nx, len_nx;
    logic [MISS_W-1:0]   miss, miss_nx, miss_inc;
    logic [SYM_BITS-1:0] sym, dout_nx;
    logic                unmet, boundary, is_pre, is_sfd0, is_sfd1;
    logic                valid_nx, det_nx, done_nx, lost_nx;

    ppm_m_demod_correlator #(
        .SYM_BITS     (SYM_BITS),
        .CHIP_SAMPLES (CHIP_SAMPLES)
    ) u_corr (
        .window    (window),
        .threshold (corr_threshold),
        .sym       (sym),
        .unmet     (unmet)
    );

    assign boundary = (cnt == CNT_W'(WIN-1));
    assign is_pre   = (sym == SYM_BITS'(PREAMBLE_SYMBOL));
    assign is_sfd0  = (sym == SYM_BITS'(SFD0_SYMBOL));
    assign is_sfd1  = (sym == SYM_BITS'(SFD1_SYMBOL));
    assign state_sc = state;

    // Oldest sample settles in bit 0, so chip 0 is the first chip in time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            window <= '0;
        end else if (rx_abort) begin
            window <= '0;
        end else if (state != ST_IDLE) begin
            window <= {din, window[WIN-1:1]};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            run             <= '0;
            hdr_cnt         <= '0;
            dcnt            <= '0;
            miss            <= '0;
            data_len        <= '0;
            dout            <= '0;
            dout_valid      <= 1'b0;
            packet_detected <= 1'b0;
            packet_done     <= 1'b0;
            carrier_lost    <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            run             <= run_nx;
            hdr_cnt         <= hdr_nx;
            dcnt            <= dcnt_nx;
            miss            <= miss_nx;
            data_len        <= len_nx;
            dout            <= dout_nx;
            dout_valid      <= valid_nx;
            packet_detected <= det_nx;
            packet_done     <= done_nx;
            carrier_lost    <= lost_nx;
        end
    end

    // Next-state and next-output logic; rx_abort overrides everything last.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        run_nx   = run;
        hdr_nx   = hdr_cnt;
        dcnt_nx  = dcnt;
        miss_nx  = miss;
        len_nx   = data_len;
        dout_nx  = dout;
        valid_nx = 1'b0;
        det_nx   = 1'b0;
        done_nx  = 1'b0;
        lost_nx  = 1'b0;
        miss_inc = unmet ? miss + MISS_W'(1) : '0;

        if (state != ST_IDLE) begin
            cnt_nx = boundary ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (rx_start) begin
                    state_nx = ST_SCAN;
                    cnt_nx   = '0;
                    run_nx   = '0;
                    hdr_nx   = '0;
                    dcnt_nx  = '0;
                    miss_nx  = '0;
                end
            end
            ST_SCAN: begin
                if (is_pre && !unmet) begin
                    run_nx   = RUN_W'(1);
                    cnt_nx   = '0;
                    state_nx = (PREAMBLE_MIN == 1) ? ST_SFD : ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (boundary) begin
                    if (run >= RUN_W'(PREAMBLE_MIN)) begin
                        state_nx = is_sfd0 ? ST_SFD : ST_SCAN;
                    end else if (is_pre && !unmet) begin
                        run_nx = run + RUN_W'(1);
                    end else begin
                        state_nx = ST_SCAN;
                    end
                end
            end
            ST_SFD: begin
                if (boundary) begin
                    if (is_sfd1) begin
                        state_nx = ST_HEADER;
                        hdr_nx   = '0;
                    end else begin
                        state_nx = ST_SCAN;
                    end
                end
            end
            ST_HEADER: begin
                if (boundary) begin
                    len_nx = (data_len << SYM_BITS) | LEN_W'(sym);
                    hdr_nx = hdr_cnt + HDR_W'(1);
                    if (hdr_cnt == HDR_W'(LEN_SYMS-1)) begin
                        if (len_nx == '0) begin
                            done_nx  = 1'b1;
                            state_nx = ST_IDLE;
                        end else begin
                            state_nx = ST_DATA;
                            dcnt_nx  = '0;
                            miss_nx  = '0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (boundary) begin
                    valid_nx = 1'b1;
                    dout_nx  = sym;
                    det_nx   = (dcnt == '0);
                    dcnt_nx  = dcnt + LEN_W'(1);
                    miss_nx  = miss_inc;
                    // Carrier loss takes precedence over completing the packet.
                    if (miss_inc == MISS_W'(MISS_MAX)) begin
                        lost_nx  = 1'b1;
                        state_nx = ST_SCAN;
                    end else if (dcnt == data_len - LEN_W'(1)) begin
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (rx_abort) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            run_nx   = '0;
            hdr_nx   = '0;
            dcnt_nx  = '0;
            miss_nx  = '0;
            len_nx   = data_len;
            dout_nx  = dout;
            valid_nx = 1'b0;
            det_nx   = 1'b0;
            done_nx  = 1'b0;
            lost_nx  = 1'b0;
        end
    end

    // Sticky overrun: a symbol was presented while the FIFO could not take it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (dout_valid && !dout_ready) begin
            overrun <= 1'b1;
        end else if (state == ST_IDLE && rx_start && !rx_abort) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ppm_m_demod.sv
// Scoreboard bench for ppm_m_demod: packets are built at symbol level, the
// expected output events are queued with their due cycle, and a monitor pops
// and compares each event the DUT presents.
module tb_ppm_m_demod;
    localparam int WIN      = 32;
    localparam int LEN_SYMS = 4;
    localparam int MISS_MAX = 3;
    localparam int PRE      = 15;
    localparam int SFD0     = 9;
    localparam int SFD1     = 6;
    localparam int ST_IDLE  = 0;
    localparam int ST_SCAN  = 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        din = 1'b0;
    logic        rx_start = 1'b0;
    logic        rx_abort = 1'b0;
    logic        dout_ready = 1'b1;
    logic [1:0]  corr_threshold = 2'd2;
    logic        dout_valid;
    logic [3:0]  dout;
    logic        packet_detected, packet_done, carrier_lost, overrun;
    logic [15:0] data_len;
    logic [2:0]  state_sc;

    ppm_m_demod dut (
        .clk             (clk),
        .resetn          (resetn),
        .din             (din),
        .rx_start        (rx_start),
        .rx_abort        (rx_abort),
        .corr_threshold  (corr_threshold),
        .dout_ready      (dout_ready),
        .dout_valid      (dout_valid),
        .dout            (dout),
        .packet_detected (packet_detected),
        .packet_done     (packet_done),
        .carrier_lost    (carrier_lost),
        .overrun         (overrun),
        .data_len        (data_len),
        .state_sc        (state_sc)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; bit v; int d; bit det; bit done; bit lost; } exp_t;
    typedef struct { int kind; int a; int b; bit rdy; } dsym_t;   // kind: 0 clean, 1 noisy, 2 tie, 3 empty

    exp_t  sb_q[$];
    dsym_t dq[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    bit    next_ready = 1'b1;
    bit    exp_ovr = 1'b0;
    int    exp_state = ST_IDLE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    exp_t mon_e;
    bit   mon_ok;
    always @(negedge clk) begin
        if (resetn && (dout_valid || packet_done || carrier_lost || packet_detected)) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: cyc %0d v=%0b d=%0h det=%0b done=%0b lost=%0b, no event expected",
                         cyc, dout_valid, dout, packet_detected, packet_done, carrier_lost);
            end else begin
                mon_e  = sb_q.pop_front();
                mon_ok = (cyc == mon_e.cyc) && (dout_valid == mon_e.v) &&
                         (!mon_e.v || dout == mon_e.d[3:0]) && (packet_detected == mon_e.det) &&
                         (packet_done == mon_e.done) && (carrier_lost == mon_e.lost);
                if (!mon_ok) begin
                    miscompares++;
                    $display("FAIL event: got cyc %0d v=%0b d=%0h det=%0b done=%0b lost=%0b, expected cyc %0d v=%0b d=%0h det=%0b done=%0b lost=%0b",
                             cyc, dout_valid, dout, packet_detected, packet_done, carrier_lost,
                             mon_e.cyc, mon_e.v, mon_e.d, mon_e.det, mon_e.done, mon_e.lost);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIN-1:0] chip_pat(input int s);
        logic [WIN-1:0] p = '0;
        p[2*s]   = 1'b1;
        p[2*s+1] = 1'b1;
        return p;
    endfunction

    function automatic dsym_t mk(input int kind, input int a, input int b, input bit rdy);
        dsym_t d;
        d.kind = kind; d.a = a; d.b = b; d.rdy = rdy;
        return d;
    endfunction

    function automatic dsym_t rand_dsym();
        dsym_t d;
        int k;
        k = $urandom_range(0, 9);
        d.rdy = ($urandom_range(0, 3) != 0);
        d.a = $urandom_range(0, 15);
        d.b = 0;
        if (k < 6) d.kind = 0;
        else if (k == 6) begin d.kind = 1; d.b = (d.a + $urandom_range(1, 15)) % 16; end
        else if (k == 7) begin d.kind = 2; d.a = $urandom_range(0, 14); d.b = $urandom_range(d.a + 1, 15); end
        else d.kind = 3;
        return d;
    endfunction

    task automatic send_sample(input bit b);
        @(negedge clk);
        din = b;
        dout_ready = next_ready;
    endtask

    task automatic send_pat(input logic [WIN-1:0] p);
        for (int i = 0; i < WIN; i++) send_sample(p[i]);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) send_sample(1'b0);
    endtask

    task automatic start_rx();
        @(negedge clk); rx_start = 1'b1; din = 1'b0;
        @(negedge clk); rx_start = 1'b0;
        exp_ovr = 1'b0;
        exp_state = ST_SCAN;
        chk("state_after_start", 32'(state_sc), ST_SCAN);
        chk("overrun_after_start", 32'(overrun), 0);
    endtask

    task automatic abort_rx();
        @(negedge clk); rx_abort = 1'b1; din = 1'b0;
        @(negedge clk); rx_abort = 1'b0;
        exp_state = ST_IDLE;
        chk("state_after_abort", 32'(state_sc), ST_IDLE);
    endtask

    // One framed packet; data symbols come from dq. wrong_sfd >= 0 replaces
    // SFD0 with that symbol, abort_at > 0 aborts inside the next data symbol.
    task automatic send_packet(input int len, input int wrong_sfd, input int abort_at, input bit expect_lock);
        int             miss;
        int             e_d;
        int             peak;
        bit             lost;
        bit             unm;
        logic [WIN-1:0] p;
        dsym_t          d;
        exp_t           e;
        miss = 0;
        lost = 1'b0;
        send_pat('0);
        send_pat(chip_pat(PRE));
        send_pat(chip_pat(PRE));
        if (wrong_sfd >= 0) begin
            send_pat(chip_pat(wrong_sfd));
            idle_cycles(2);
            exp_state = ST_SCAN;
            chk("state_after_bad_sfd", 32'(state_sc), ST_SCAN);
            return;
        end
        send_pat(chip_pat(SFD0));
        send_pat(chip_pat(SFD1));
        for (int h = LEN_SYMS - 1; h >= 0; h--) send_pat(chip_pat((len >> (4*h)) & 15));
        if (expect_lock && len == 0) begin
            e.cyc = cyc + 2; e.v = 1'b0; e.d = 0; e.det = 1'b0; e.done = 1'b1; e.lost = 1'b0;
            sb_q.push_back(e);
        end
        for (int i = 0; i < len && expect_lock; i++) begin
            d = dq.pop_front();
            case (d.kind)
                0: p = chip_pat(d.a);
                1: begin p = chip_pat(d.a); p[2*d.b + int'($urandom_range(0, 1))] = 1'b1; end
                2: p = chip_pat(d.a) | chip_pat(d.b);
                default: p = '0;
            endcase
            send_pat(p);
            peak = (d.kind == 3) ? 0 : 2;
            e_d  = (d.kind == 3) ? 0 : d.a;
            unm  = (peak < int'(corr_threshold));
            miss = unm ? miss + 1 : 0;
            lost = (miss == MISS_MAX);
            e.cyc = cyc + 2; e.v = 1'b1; e.d = e_d; e.det = (i == 0);
            e.lost = lost; e.done = !lost && (i == len - 1);
            sb_q.push_back(e);
            if (!d.rdy) exp_ovr = 1'b1;
            next_ready = d.rdy;
            if (lost) break;
            if (i + 1 == abort_at) begin
                for (int k = 0; k < 10; k++) send_sample(1'($urandom_range(0, 1)));
                abort_rx();
                chk("overrun_kept_on_abort", 32'(overrun), 32'(exp_ovr));
                chk("data_len_kept_on_abort", 32'(data_len), len);
                next_ready = 1'b1;
                dq.delete();
                return;
            end
        end
        idle_cycles(3);
        next_ready = 1'b1;
        if (!expect_lock) exp_state = ST_SCAN;
        else exp_state = lost ? ST_SCAN : ST_IDLE;
        chk("state_after_packet", 32'(state_sc), exp_state);
        chk("overrun_after_packet", 32'(overrun), 32'(exp_ovr));
        if (expect_lock) chk("data_len", 32'(data_len), len);
        dq.delete();
    endtask

    initial begin
        int len;
        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state_sc), ST_IDLE);
        chk("reset_dout_valid", 32'(dout_valid), 0);
        chk("reset_dout", 32'(dout), 0);
        chk("reset_pulses", 32'({packet_detected, packet_done, carrier_lost}), 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_data_len", 32'(data_len), 0);
        @(negedge clk); resetn = 1'b1;
        idle_cycles(4);
        chk("idle_holds", 32'(state_sc), ST_IDLE);

        // Clean packet 5, A, F
        start_rx();
        dq.push_back(mk(0, 5, 0, 1)); dq.push_back(mk(0, 10, 0, 1)); dq.push_back(mk(0, 15, 0, 1));
        send_packet(3, -1, 0, 1);

        // Zero length
        start_rx();
        send_packet(0, -1, 0, 1);

        // Bad SFD0, then a good packet from SCAN
        start_rx();
        send_packet(0, 3, 0, 1);
        for (int i = 0; i < 3; i++) dq.push_back(rand_dsym());
        send_packet(3, -1, 0, 1);

        // Ties resolve to the lower index
        start_rx();
        dq.push_back(mk(2, 2, 7, 1)); dq.push_back(mk(2, 0, 15, 1)); dq.push_back(mk(2, 14, 15, 1));
        send_packet(3, -1, 0, 1);

        // Threshold above any reachable magnitude: never locks
        start_rx();
        corr_threshold = 2'd3;
        send_packet(0, -1, 0, 0);
        abort_rx();
        corr_threshold = 2'd2;

        // Carrier loss after three empty symbols
        start_rx();
        dq.push_back(mk(0, 3, 0, 1));
        for (int i = 0; i < 3; i++) dq.push_back(mk(3, 0, 0, 1));
        dq.push_back(mk(0, 4, 0, 1));
        send_packet(5, -1, 0, 1);

        // Overrun on symbol 2, abort mid-data, rx_start clears overrun
        abort_rx();
        start_rx();
        dq.push_back(mk(0, 1, 0, 1)); dq.push_back(mk(0, 2, 0, 0));
        dq.push_back(mk(0, 3, 0, 1)); dq.push_back(mk(0, 4, 0, 1));
        send_packet(4, -1, 3, 1);
        start_rx();

        // Randomized packets
        for (int n = 0; n < 20; n++) begin
            if (exp_state == ST_IDLE) start_rx();
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) dq.push_back(rand_dsym());
            send_packet(len, -1, 0, 1);
        end

        idle_cycles(40);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
